sync_fifo_buffer: RTL and testbench
===================================

# sync_fifo_buffer

Single-clock, parametrised FIFO for buffering received UART bytes ahead of the consumer logic. It holds its own dual-port storage and read/write pointers, and keeps a live occupancy count. It provides full, empty, almost-full and almost-empty flags plus sticky overflow/underflow error flags. A FWFT parameter selects either first-word-fall-through or registered-read output.

## Interface
- DATASIZE, 8, width of one entry in bits
- ADDRSIZE, 4, pointer width; depth DEPTH = 2**ADDRSIZE
- AFULL_LVL, DEPTH-2, almost-full asserted when count >= AFULL_LVL
- AEMPTY_LVL, 2, almost-empty asserted when count <= AEMPTY_LVL
- FWFT, 1, 1 = first-word-fall-through; 0 = registered read with one-cycle latency
- wclk  input  1  sole clock; all state updates on rising edge
- wrst  input  1  asynchronous, active-high reset
- winc  input  1  write request
- wdata  input  DATASIZE  write data, sampled when winc accepted
- rinc  input  1  read/pop request
- clr_err  input  1  synchronous clear of ovf and udf
- rdata  output  DATASIZE  read data
- rvalid  output  1  rdata holds a valid entry
- wfull  output  1  count == DEPTH
- rempty  output  1  count == 0
- afull  output  1  almost-full
- aempty  output  1  almost-empty
- count  output  ADDRSIZE+1  number of stored entries, 0..DEPTH
- ovf  output  1  sticky: write attempted while wfull
- udf  output  1  sticky: read attempted while rempty

## Operation
- Write accepted iff winc && !wfull. It stores wdata at waddr, and waddr increments modulo DEPTH.
- Read accepted iff rinc && !rempty. raddr increments modulo DEPTH.
- Flags are evaluated on the registered pre-edge count. A write while full is rejected even if rinc is accepted in the same cycle. A read while empty is rejected even if winc is accepted in the same cycle.
- count update: +1 write only, -1 read only, unchanged when both are accepted or neither is. Pointers wrap silently.
- wfull, rempty, afull and aempty are registered and derived from the next-state count, so they are valid in the same cycle as count.
- ovf sets on winc && wfull. udf sets on rinc && rempty. Both hold until clr_err or wrst. If clr_err and a new error coincide, the set wins.
- FWFT=1:
  - rdata is driven combinationally from mem[raddr]; rvalid = !rempty.
  - rinc acknowledges the shown word; the next word appears after the edge.
- FWFT=0:
  - An accepted read registers mem[raddr] into rdata, and rvalid pulses high for exactly one cycle.
  - rdata holds its value until the next accepted read.
- Memory contents are not reset. An entry is never written outside an accepted write.

## Timing
- Reset values: count=0, rempty=1, wfull=0, afull=0, aempty=1, ovf=0, udf=0, rvalid=0, rdata=0 (FWFT=0), pointers=0.
- Reset is asynchronous assert with synchronous deassert use. Reset during traffic discards all stored entries immediately.
- Write to first visibility:
  - FWFT=1: word written at edge N; rempty falls and rdata is valid after edge N, i.e. in cycle N+1.
  - FWFT=0: earliest accepted rinc is in cycle N+1; data and rvalid appear after edge N+1.
- Sustained throughput is one write and one read per cycle, including at full (read only) and empty (write only).
- Flags change only on wclk edges, except the asynchronous reset.

## Structure
- Shared package fifo_pkg:
  - DEPTH derivation (1 << ADDRSIZE).
  - Count-width constant (ADDRSIZE+1).
  - Default threshold constants used by the UART receiver top.
- One sub-module, fifo_dpram:
  - DEPTH x DATASIZE storage with a synchronous write port and an asynchronous read port.
  - No reset.
  - Write is gated only by its wen input, which the parent drives as winc && !wfull.
- Pointer/count/flag logic and the FWFT output stage live in sync_fifo_buffer.

## Test plan
All scenarios use defaults unless stated.
- Reset then idle: assert wrst mid-cycle → count=0, rempty=1, aempty=1, wfull=0, ovf=udf=0 immediately.
- Fill/drain: write 0x00..0x0F on 16 consecutive cycles.
  - Expect afull at count=14, wfull at count=16.
  - Then read 16 → data 0x00..0x0F in order, rempty after the last read.
- Overflow: at full, winc with 0xAA and rinc together.
  - The read is accepted and the write rejected; count=15 and ovf=1.
  - 0xAA never appears at the output.
  - clr_err then clears ovf.
- Underflow: with the FIFO empty, winc=0x55 and rinc together.
  - The write is accepted and the read rejected; count=1, udf=1.
  - The next read returns 0x55.
- Wrap-around: run 40 cycles of simultaneous write/read at count=3.
  - count stays 3 throughout; the output sequence equals the input sequence delayed by 3 entries.
- FWFT=0: write 0x12, then rinc → rdata=0x12 with a single-cycle rvalid pulse one edge later; rdata holds 0x12 afterwards.

Source files
------------

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the receive-side byte FIFO.
//   fifo_depth()   : number of entries for a given pointer width
//   fifo_cw()      : width of an occupancy counter able to hold 0..DEPTH
//   UART_*         : default sizing/threshold values used by the UART receiver
// ----------------------------------------------------------------------------
package fifo_pkg;

  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

  // One extra bit so a completely full FIFO (count == DEPTH) is representable.
  function automatic int fifo_cw(input int addrsize);
    return addrsize + 1;
  endfunction

  localparam int UART_DATASIZE   = 8;
  localparam int UART_ADDRSIZE   = 4;
  localparam int UART_AFULL_LVL  = fifo_depth(UART_ADDRSIZE) - 2;
  localparam int UART_AEMPTY_LVL = 2;

endpackage

// File: rtl/sync_fifo_buffer_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_buffer_if
// Bundles the FIFO request/data/status signals.
//   master : producer/consumer side (drives winc, wdata, rinc, clr_err)
//   slave  : the FIFO itself (drives rdata, rvalid, flags, count, errors)
//
// Handshake: a write is taken on a rising clock edge when winc=1 and wfull=0
// (wfull acts as the inverted ready of the write side); a read is taken when
// rinc=1 and rempty=0. Requests made against a full/empty FIFO are dropped and
// recorded in the sticky ovf/udf flags instead.
// ----------------------------------------------------------------------------
interface sync_fifo_buffer_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);

  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                rinc;
  logic                clr_err;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;
  logic                wfull;
  logic                rempty;
  logic                afull;
  logic                aempty;
  logic [ADDRSIZE:0]   count;
  logic                ovf;
  logic                udf;

  modport master (
    output winc, wdata, rinc, clr_err,
    input  rdata, rvalid, wfull, rempty, afull, aempty, count, ovf, udf
  );

  modport slave (
    input  winc, wdata, rinc, clr_err,
    output rdata, rvalid, wfull, rempty, afull, aempty, count, ovf, udf
  );

endinterface

// File: rtl/fifo_dpram.sv
// ----------------------------------------------------------------------------
// fifo_dpram
// DEPTH x DATASIZE storage: synchronous write port, asynchronous read port.
// Contents are never reset.
//   clk    : write clock
//   wen    : write enable (parent gates it with "not full")
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : mem[raddr], combinational
// ----------------------------------------------------------------------------
module fifo_dpram #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                wen,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_buffer.sv
// ----------------------------------------------------------------------------
// sync_fifo_buffer
// Single-clock FIFO buffering received UART bytes for the consumer logic.
// Keeps read/write pointers, a live occupancy count, registered status flags
// and sticky error flags. FWFT selects the output stage:
//   FWFT=1 : head entry shown combinationally, rvalid = !rempty
//   FWFT=0 : accepted read loads rdata next edge, rvalid is a 1-cycle pulse
// Ports:
//   wclk : clock (all state changes on rising edge)
//   wrst : asynchronous active-high reset
//   bus  : sync_fifo_buffer_if.slave (requests, data, flags, count, errors)
// ----------------------------------------------------------------------------
module sync_fifo_buffer
  import fifo_pkg::*;
#(
  parameter int DATASIZE   = 8,
  parameter int ADDRSIZE   = 4,
  parameter int AFULL_LVL  = fifo_depth(ADDRSIZE) - 2,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 1
) (
  input  logic                  wclk,
  input  logic                  wrst,
  sync_fifo_buffer_if.slave     bus
);

  localparam int DEPTH = fifo_depth(ADDRSIZE);
  localparam int CW    = fifo_cw(ADDRSIZE);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE-1:0] raddr;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_next;
  logic                wfull_q;
  logic                rempty_q;
  logic                afull_q;
  logic                aempty_q;
  logic                ovf_q;
  logic                udf_q;
  logic                wr_acc;
  logic                rd_acc;
  logic [DATASIZE-1:0] mem_rdata;

  // Acceptance uses the registered (pre-edge) flags, so a write into a full
  // FIFO is refused even if a read frees a slot in the same cycle, and a read
  // from an empty FIFO is refused even if a write lands in the same cycle.
  assign wr_acc = bus.winc && !wfull_q;
  assign rd_acc = bus.rinc && !rempty_q;

  always_comb begin
    count_next = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  fifo_dpram #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .clk   (wclk),
    .wen   (wr_acc),
    .waddr (waddr),
    .wdata (bus.wdata),
    .raddr (raddr),
    .rdata (mem_rdata)
  );

  // Flags are computed from count_next so they line up with count itself.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      waddr    <= '0;
      raddr    <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        waddr <= waddr + ADDRSIZE'(1);
      end
      if (rd_acc) begin
        raddr <= raddr + ADDRSIZE'(1);
      end
      count_q  <= count_next;
      wfull_q  <= (count_next == DEPTH_C);
      rempty_q <= (count_next == '0);
      afull_q  <= (count_next >= AFULL_C);
      aempty_q <= (count_next <= AEMPTY_C);
      // A new error in the same cycle as clr_err keeps the flag set.
      if (bus.winc && wfull_q) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_err) begin
        ovf_q <= 1'b0;
      end
      if (bus.rinc && rempty_q) begin
        udf_q <= 1'b1;
      end else if (bus.clr_err) begin
        udf_q <= 1'b0;
      end
    end
  end

  assign bus.count  = count_q;
  assign bus.wfull  = wfull_q;
  assign bus.rempty = rempty_q;
  assign bus.afull  = afull_q;
  assign bus.aempty = aempty_q;
  assign bus.ovf    = ovf_q;
  assign bus.udf    = udf_q;

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is always presented; rinc acknowledges it.
      assign bus.rdata  = mem_rdata;
      assign bus.rvalid = !rempty_q;
    end else begin : g_regread
      logic [DATASIZE-1:0] rdata_q;
      logic                rvalid_q;

      always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_acc;
          if (rd_acc) begin
            rdata_q <= mem_rdata;
          end
        end
      end

      assign bus.rdata  = rdata_q;
      assign bus.rvalid = rvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_buffer
// Directed bench for sync_fifo_buffer: one FWFT=1 instance (b1) and one
// FWFT=0 instance (b0) sharing clock and reset.
// ----------------------------------------------------------------------------
module tb_sync_fifo_buffer;

  logic wclk;
  logic wrst;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  sync_fifo_buffer_if #(.DATASIZE(8), .ADDRSIZE(4)) b1 ();
  sync_fifo_buffer_if #(.DATASIZE(8), .ADDRSIZE(4)) b0 ();

  sync_fifo_buffer #(.FWFT(1)) u_dut_fwft (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (b1)
  );

  sync_fifo_buffer #(.FWFT(0)) u_dut_reg (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (b0)
  );

  // ---------------- clock / reset ----------------
  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic idle_inputs();
    b1.winc = 1'b0; b1.wdata = 8'h00; b1.rinc = 1'b0; b1.clr_err = 1'b0;
    b0.winc = 1'b0; b0.wdata = 8'h00; b0.rinc = 1'b0; b0.clr_err = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Create an underflow and some stored entries, then reset mid-cycle.
    b1.rinc = 1'b1;
    tick();
    b1.rinc = 1'b0;
    n_checks++; if (b1.udf !== 1'b1) begin n_fail++; $display("FAIL pre_reset_udf: got %b exp 1", b1.udf); end
    for (int i = 0; i < 3; i++) begin
      b1.winc = 1'b1; b1.wdata = 8'hC0 + 8'(i);
      tick();
    end
    b1.winc = 1'b0;
    n_checks++; if (b1.count !== 5'd3) begin n_fail++; $display("FAIL pre_reset_count: got %0d exp 3", b1.count); end
    #2 wrst = 1'b1;
    #1;
    n_checks++; if (b1.count !== 5'd0)  begin n_fail++; $display("FAIL reset_count: got %0d exp 0", b1.count); end
    n_checks++; if (b1.rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty: got %b exp 1", b1.rempty); end
    n_checks++; if (b1.aempty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b exp 1", b1.aempty); end
    n_checks++; if (b1.wfull !== 1'b0)  begin n_fail++; $display("FAIL reset_wfull: got %b exp 0", b1.wfull); end
    n_checks++; if (b1.afull !== 1'b0)  begin n_fail++; $display("FAIL reset_afull: got %b exp 0", b1.afull); end
    n_checks++; if (b1.ovf !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf: got %b exp 0", b1.ovf); end
    n_checks++; if (b1.udf !== 1'b0)    begin n_fail++; $display("FAIL reset_udf: got %b exp 0", b1.udf); end
    n_checks++; if (b1.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_fwft: got %b exp 0", b1.rvalid); end
    n_checks++; if (b0.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_reg: got %b exp 0", b0.rvalid); end
    n_checks++; if (b0.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata_reg: got %h exp 00", b0.rdata); end
    @(negedge wclk);
    wrst = 1'b0;
    tick();
    n_checks++; if (b1.count !== 5'd0) begin n_fail++; $display("FAIL post_reset_idle_count: got %0d exp 0", b1.count); end
  endtask

  task automatic test_fill_drain();
    logic [4:0] exp_cnt;
    for (int i = 0; i < 16; i++) begin
      b1.winc = 1'b1; b1.wdata = 8'(i);
      tick();
      exp_cnt = 5'(i + 1);
      n_checks++; if (b1.count !== exp_cnt) begin n_fail++; $display("FAIL fill_count: got %0d exp %0d", b1.count, exp_cnt); end
      n_checks++; if (b1.afull !== (exp_cnt >= 5'd14)) begin n_fail++; $display("FAIL fill_afull at %0d: got %b exp %b", exp_cnt, b1.afull, exp_cnt >= 5'd14); end
      n_checks++; if (b1.wfull !== (exp_cnt == 5'd16)) begin n_fail++; $display("FAIL fill_wfull at %0d: got %b exp %b", exp_cnt, b1.wfull, exp_cnt == 5'd16); end
      n_checks++; if (b1.aempty !== (exp_cnt <= 5'd2)) begin n_fail++; $display("FAIL fill_aempty at %0d: got %b exp %b", exp_cnt, b1.aempty, exp_cnt <= 5'd2); end
    end
    b1.winc = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (b1.rdata !== 8'(i)) begin n_fail++; $display("FAIL drain_data: got %h exp %h", b1.rdata, 8'(i)); end
      n_checks++; if (b1.rvalid !== 1'b1) begin n_fail++; $display("FAIL drain_rvalid: got %b exp 1", b1.rvalid); end
      b1.rinc = 1'b1;
      tick();
      exp_cnt = 5'(15 - i);
      n_checks++; if (b1.count !== exp_cnt) begin n_fail++; $display("FAIL drain_count: got %0d exp %0d", b1.count, exp_cnt); end
    end
    b1.rinc = 1'b0;
    n_checks++; if (b1.rempty !== 1'b1) begin n_fail++; $display("FAIL drain_rempty: got %b exp 1", b1.rempty); end
    n_checks++; if (b1.udf !== 1'b0)    begin n_fail++; $display("FAIL drain_no_udf: got %b exp 0", b1.udf); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      b1.winc = 1'b1; b1.wdata = 8'h20 + 8'(i);
      tick();
    end
    n_checks++; if (b1.wfull !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b exp 1", b1.wfull); end
    b1.winc = 1'b1; b1.wdata = 8'hAA; b1.rinc = 1'b1;
    n_checks++; if (b1.rdata !== 8'h20) begin n_fail++; $display("FAIL ovf_head: got %h exp 20", b1.rdata); end
    tick();
    b1.winc = 1'b0; b1.rinc = 1'b0;
    n_checks++; if (b1.count !== 5'd15) begin n_fail++; $display("FAIL ovf_count: got %0d exp 15", b1.count); end
    n_checks++; if (b1.ovf !== 1'b1)    begin n_fail++; $display("FAIL ovf_flag: got %b exp 1", b1.ovf); end
    n_checks++; if (b1.wfull !== 1'b0)  begin n_fail++; $display("FAIL ovf_wfull: got %b exp 0", b1.wfull); end
    tick();
    n_checks++; if (b1.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b exp 1", b1.ovf); end
    b1.clr_err = 1'b1;
    tick();
    b1.clr_err = 1'b0;
    n_checks++; if (b1.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b exp 0", b1.ovf); end
    for (int i = 1; i < 16; i++) begin
      n_checks++; if (b1.rdata !== 8'h20 + 8'(i)) begin n_fail++; $display("FAIL ovf_drain_data: got %h exp %h", b1.rdata, 8'h20 + 8'(i)); end
      b1.rinc = 1'b1;
      tick();
    end
    b1.rinc = 1'b0;
    n_checks++; if (b1.rempty !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_empty: got %b exp 1", b1.rempty); end
  endtask

  task automatic test_underflow();
    b1.winc = 1'b1; b1.wdata = 8'h55; b1.rinc = 1'b1;
    tick();
    b1.winc = 1'b0; b1.rinc = 1'b0;
    n_checks++; if (b1.count !== 5'd1)  begin n_fail++; $display("FAIL udf_count: got %0d exp 1", b1.count); end
    n_checks++; if (b1.udf !== 1'b1)    begin n_fail++; $display("FAIL udf_flag: got %b exp 1", b1.udf); end
    n_checks++; if (b1.rempty !== 1'b0) begin n_fail++; $display("FAIL udf_rempty: got %b exp 0", b1.rempty); end
    n_checks++; if (b1.rdata !== 8'h55) begin n_fail++; $display("FAIL udf_data: got %h exp 55", b1.rdata); end
    b1.rinc = 1'b1;
    tick();
    n_checks++; if (b1.count !== 5'd0) begin n_fail++; $display("FAIL udf_pop_count: got %0d exp 0", b1.count); end
    // Empty again: a fresh underflow coinciding with clr_err keeps udf set.
    b1.clr_err = 1'b1;
    tick();
    b1.rinc = 1'b0;
    n_checks++; if (b1.udf !== 1'b1) begin n_fail++; $display("FAIL udf_set_wins: got %b exp 1", b1.udf); end
    tick();
    b1.clr_err = 1'b0;
    n_checks++; if (b1.udf !== 1'b0) begin n_fail++; $display("FAIL udf_clear: got %b exp 0", b1.udf); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      b1.winc = 1'b1; b1.wdata = 8'h60 + 8'(i);
      exp_q.push_back(b1.wdata);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      b1.winc = 1'b1; b1.wdata = 8'h80 + 8'(i); b1.rinc = 1'b1;
      exp_d = exp_q.pop_front();
      exp_q.push_back(b1.wdata);
      n_checks++; if (b1.rdata !== exp_d) begin n_fail++; $display("FAIL wrap_data cycle %0d: got %h exp %h", i, b1.rdata, exp_d); end
      tick();
      n_checks++; if (b1.count !== 5'd3) begin n_fail++; $display("FAIL wrap_count cycle %0d: got %0d exp 3", i, b1.count); end
    end
    b1.winc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_d = exp_q.pop_front();
      n_checks++; if (b1.rdata !== exp_d) begin n_fail++; $display("FAIL wrap_tail: got %h exp %h", b1.rdata, exp_d); end
      tick();
    end
    b1.rinc = 1'b0;
    n_checks++; if (b1.rempty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b exp 1", b1.rempty); end
  endtask

  task automatic test_fwft0();
    b0.winc = 1'b1; b0.wdata = 8'h12;
    tick();
    b0.winc = 1'b0;
    n_checks++; if (b0.rvalid !== 1'b0) begin n_fail++; $display("FAIL reg_rvalid_before: got %b exp 0", b0.rvalid); end
    n_checks++; if (b0.rempty !== 1'b0) begin n_fail++; $display("FAIL reg_rempty: got %b exp 0", b0.rempty); end
    b0.rinc = 1'b1;
    tick();
    b0.rinc = 1'b0;
    n_checks++; if (b0.rvalid !== 1'b1) begin n_fail++; $display("FAIL reg_rvalid_pulse: got %b exp 1", b0.rvalid); end
    n_checks++; if (b0.rdata !== 8'h12) begin n_fail++; $display("FAIL reg_rdata: got %h exp 12", b0.rdata); end
    tick();
    n_checks++; if (b0.rvalid !== 1'b0) begin n_fail++; $display("FAIL reg_rvalid_drop: got %b exp 0", b0.rvalid); end
    n_checks++; if (b0.rdata !== 8'h12) begin n_fail++; $display("FAIL reg_rdata_hold: got %h exp 12", b0.rdata); end
    n_checks++; if (b0.rempty !== 1'b1) begin n_fail++; $display("FAIL reg_rempty_after: got %b exp 1", b0.rempty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      b0.winc = 1'b1; b0.wdata = 8'(8'hA0 + 8'(i * 5));
      exp_q.push_back(b0.wdata);
      tick();
    end
    b0.winc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b0.rinc = 1'b1;
      tick();
      exp_d = exp_q.pop_front();
      n_checks++; if (b0.rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid %0d: got %b exp 1", i, b0.rvalid); end
      n_checks++; if (b0.rdata !== exp_d) begin n_fail++; $display("FAIL b2b_rdata %0d: got %h exp %h", i, b0.rdata, exp_d); end
    end
    // Read request on empty: rejected, rdata holds, no pulse, udf set.
    tick();
    b0.rinc = 1'b0;
    n_checks++; if (b0.rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty_rvalid: got %b exp 0", b0.rvalid); end
    n_checks++; if (b0.rdata !== 8'hAA) begin n_fail++; $display("FAIL b2b_hold: got %h exp aa", b0.rdata); end
    n_checks++; if (b0.udf !== 1'b1)    begin n_fail++; $display("FAIL b2b_udf: got %b exp 1", b0.udf); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    idle_inputs();
    wrst = 1'b1;
    #12;
    wrst = 1'b0;
    tick();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_fwft0();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
